// File: rtl/wifi_uart_pkg.sv
// Shared WiFi UART definitions: default line rate, oversample divider and RX state encodings.
// WIFI_UART_PARITY_EN adds the PARITY state (even parity after the data bits).
package wifi_uart_pkg;

    localparam int unsigned WIFI_CLK_HZ = 50_000_000;
    localparam int unsigned WIFI_BAUD   = 115_200;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitHigh = 3'd4
`ifdef WIFI_UART_PARITY_EN
        ,
        StParity   = 3'd5
`endif
    } rx_state_e;

    // Clocks per 16x oversample tick, truncated.
    function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud);
        return clk_hz / (baud * 16);
    endfunction

endpackage

// File: rtl/wifi_rx_fifo.sv
// wifi_rx_fifo: first-word-fall-through byte FIFO, depth 2**FIFO_AW.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module wifi_rx_fifo #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overrun
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wptr_q;
    logic [FIFO_AW:0] rptr_q;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

    // A read on a full FIFO frees the slot the same-cycle write lands in.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign overrun = wr_en && full && !do_rd;

    // Head byte is forced to zero while empty so reset shows a defined value.
    assign rd_data = empty ? 8'h00 : mem[rptr_q[FIFO_AW-1:0]];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr_q[FIFO_AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + (FIFO_AW + 1)'(1);
            end
            if (do_rd) begin
                rptr_q <= rptr_q + (FIFO_AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/wifi_uart_rx.sv
// wifi_uart_rx: 16x-oversampled UART receiver from the WiFi module into a FWFT FIFO.
// Default framing is 8N1; defining WIFI_UART_PARITY_EN adds an even parity bit.
module wifi_uart_rx
    import wifi_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ  = WIFI_CLK_HZ,
    parameter int unsigned BAUD    = WIFI_BAUD,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    rx_state_e        state_q, state_d;
    logic             rxd_m, rxd_s, rxd_q;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic [7:0]       wr_data_q;
    logic             wr_en_q;
    logic             frame_err_q;
    logic             tick;
    logic             sample;
    logic             start_edge;
    logic             par_bad;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_q <= rxd_s;
        end
    end

    assign start_edge = (state_q == StIdle) && rxd_q && !rxd_s;

    // Oversample divider, realigned to each start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start_edge || div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1)) && !start_edge;

    // Ticks since the last sample; mid start bit at 8, every later bit 16 on (4-bit wrap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (start_edge || (sample && state_q == StStart)) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    assign sample = tick && (tick_cnt == ((state_q == StStart) ? 4'd7 : 4'd15));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_edge) state_d = StStart;
            end
            StStart: begin
                if (sample) state_d = rxd_s ? StIdle : StData;
            end
            StData: begin
                if (sample && bit_cnt == 3'd7) begin
`ifdef WIFI_UART_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef WIFI_UART_PARITY_EN
            StParity: begin
                if (sample) state_d = StStop;
            end
`endif
            StStop: begin
                if (sample) state_d = rxd_s ? StIdle : StWaitHigh;
            end
            StWaitHigh: begin
                if (rxd_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Data shift, bit count and the registered FIFO write / frame error strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (sample) begin
                case (state_q)
                    StStart: bit_cnt <= '0;
                    StData: begin
                        shift_q <= {rxd_s, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    StStop: begin
                        if (rxd_s) begin
                            wr_en_q   <= !par_bad;
                            wr_data_q <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign frame_err = frame_err_q;

`ifdef WIFI_UART_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;

    // Even parity check; a bad frame is remembered until the stop sample drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            if (sample && state_q == StStart) begin
                par_bad_q <= 1'b0;
            end else if (sample && state_q == StParity && (rxd_s != ^shift_q)) begin
                par_bad_q    <= 1'b1;
                parity_err_q <= 1'b1;
            end
        end
    end

    assign par_bad    = par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    wifi_rx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_q),
        .wr_data (wr_data_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_wifi_uart_rx.sv
// Bench for wifi_uart_rx: instance u_a at default rates (432 clocks/bit), instance u_b at a
// faster baud (96 clocks/bit) for the FIFO fill tests. Expected bytes go through a queue.
module tb_wifi_uart_rx;
    import wifi_uart_pkg::*;

    localparam int BIT_A = 432;  // 50 MHz / 115200, divider 27 x 16
    localparam int BIT_B = 96;   // 50 MHz / 460800, divider 6 x 16

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd [2];
    logic       rd_en [2];
    logic [7:0] rd_data [2];
    logic       empty [2];
    logic       full [2];
    logic       overrun [2];
    logic       frame_err [2];
    logic       parity_err [2];

    int ovr_n [2] = '{0, 0};
    int fe_n  [2] = '{0, 0};
    int pe_n  [2] = '{0, 0};
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    wifi_uart_rx u_a (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd[0]),
        .rd_en      (rd_en[0]),
        .rd_data    (rd_data[0]),
        .empty      (empty[0]),
        .full       (full[0]),
        .overrun    (overrun[0]),
        .frame_err  (frame_err[0]),
        .parity_err (parity_err[0])
    );

    wifi_uart_rx #(
        .BAUD (460_800)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd[1]),
        .rd_en      (rd_en[1]),
        .rd_data    (rd_data[1]),
        .empty      (empty[1]),
        .full       (full[1]),
        .overrun    (overrun[1]),
        .frame_err  (frame_err[1]),
        .parity_err (parity_err[1])
    );

    // Count cycles each flag is high; a clean single pulse adds exactly one.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (overrun[i])    ovr_n[i]++;
            if (frame_err[i])  fe_n[i]++;
            if (parity_err[i]) pe_n[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rxd(input int s, input logic v, input int len);
        rxd[s] = v;
        repeat (len) @(posedge clk);
    endtask

    // One frame: start, 8 data LSB first, optional even parity (flip_par corrupts it), stop,
    // then one idle bit so the write has landed when the task returns.
    task automatic send_byte(input int s, input logic [7:0] d, input logic stop_v,
                             input logic flip_par);
        int len;
        len = (s == 0) ? BIT_A : BIT_B;
        set_rxd(s, 1'b0, len);
        for (int i = 0; i < 8; i++) set_rxd(s, d[i], len);
`ifdef WIFI_UART_PARITY_EN
        set_rxd(s, (^d) ^ flip_par, len);
`else
        if (flip_par) $display("note: parity flip ignored in 8N1 build");
`endif
        set_rxd(s, stop_v, len);
        set_rxd(s, 1'b1, len);
    endtask

    // Wait (bounded) for data, compare the head with the scoreboard, then pop it.
    task automatic read_check(input int s, input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        @(negedge clk);
        while (empty[s] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_avail"}, empty[s], 1'b0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, rd_data[s], e);
        end
        rd_en[s] = 1'b1;
        @(negedge clk);
        rd_en[s] = 1'b0;
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr0, fe0, pe0, n;

        rst      = 1'b1;
        rxd[0]   = 1'b1;
        rxd[1]   = 1'b1;
        rd_en[0] = 1'b0;
        rd_en[1] = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state.
        check("rst_empty",      empty[0], 1'b1);
        check("rst_full",       full[0], 1'b0);
        check("rst_rd_data",    rd_data[0], 8'h00);
        check("rst_overrun",    overrun[0], 1'b0);
        check("rst_frame_err",  frame_err[0], 1'b0);
        check("rst_parity_err", parity_err[0], 1'b0);
        check("rst_state",      u_a.state_q, StIdle);
        check("rst_sync",       u_a.rxd_s, 1'b1);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // 0x41 at default rate.
        send_byte(0, 8'h41, 1'b1, 1'b0);
        exp_q.push_back(8'h41);
        read_check(0, "byte_41");
        check("b41_empty_after_pop", empty[0], 1'b1);
        check("b41_no_fe", 32'(fe_n[0]), 32'd0);
        check("b41_no_ovr", 32'(ovr_n[0]), 32'd0);

        // One-clock low glitch at idle.
        @(posedge clk);
        rxd[0] = 1'b0;
        @(posedge clk);
        rxd[0] = 1'b1;
        repeat (BIT_A * 2) @(posedge clk);
        @(negedge clk);
        check("glitch_empty", empty[0], 1'b1);
        check("glitch_state", u_a.state_q, StIdle);
        check("glitch_no_fe", 32'(fe_n[0]), 32'd0);
        check("glitch_no_pe", 32'(pe_n[0]), 32'd0);

        // 0x55 with a low stop bit, then 0x33 after the line returns high.
        fe0 = fe_n[0];
        send_byte(0, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        check("fe_pulse_once", 32'(fe_n[0] - fe0), 32'd1);
        check("fe_empty", empty[0], 1'b1);
        send_byte(0, 8'h33, 1'b1, 1'b0);
        exp_q.push_back(8'h33);
        read_check(0, "byte_33");
        check("b33_fe_unchanged", 32'(fe_n[0] - fe0), 32'd1);

`ifdef WIFI_UART_PARITY_EN
        // 0x03: wrong parity bit dropped, correct parity bit received.
        pe0 = pe_n[0];
        send_byte(0, 8'h03, 1'b1, 1'b1);
        @(negedge clk);
        check("par_bad_pulse", 32'(pe_n[0] - pe0), 32'd1);
        check("par_bad_empty", empty[0], 1'b1);
        send_byte(0, 8'h03, 1'b1, 1'b0);
        exp_q.push_back(8'h03);
        read_check(0, "par_good_03");
        check("par_good_no_pulse", 32'(pe_n[0] - pe0), 32'd1);
`else
        pe0 = 0;
        check("no_parity_err_8n1", 32'(pe_n[0]), 32'(pe0));
`endif

        // Reset in the middle of a frame flushes the FIFO and abandons the frame.
        send_byte(0, 8'h77, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_has_byte", empty[0], 1'b0);
        set_rxd(0, 1'b0, BIT_A);
        set_rxd(0, 1'b1, BIT_A);
        set_rxd(0, 1'b0, BIT_A / 2);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rxd[0] = 1'b1;
        rst = 1'b0;
        repeat (BIT_A * 10) @(posedge clk);
        @(negedge clk);
        check("midrst_empty", empty[0], 1'b1);
        check("midrst_rd_data", rd_data[0], 8'h00);
        check("midrst_state", u_a.state_q, StIdle);
        send_byte(0, 8'h12, 1'b1, 1'b0);
        exp_q.push_back(8'h12);
        read_check(0, "byte_12_after_rst");

        // Fast instance: 17 bytes without reads.
        ovr0 = ovr_n[1];
        for (int i = 0; i < 17; i++) begin
            send_byte(1, 8'(i), 1'b1, 1'b0);
            if (i < 16) exp_q.push_back(8'(i));
            @(negedge clk);
            if (i == 14) check("fill15_not_full", full[1], 1'b0);
            if (i == 15) begin
                check("fill16_full", full[1], 1'b1);
                check("fill16_no_ovr", 32'(ovr_n[1] - ovr0), 32'd0);
            end
        end
        check("fill17_ovr_once", 32'(ovr_n[1] - ovr0), 32'd1);
        check("fill17_full", full[1], 1'b1);

        // Full FIFO: hold rd_en across the cycle the 0xA5 write lands.
        fork
            send_byte(1, 8'hA5, 1'b1, 1'b0);
            begin : watch_wr
                n = 0;
                while (!u_b.wr_en_q && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                check("a5_write_seen", u_b.wr_en_q, 1'b1);
                check("a5_head", rd_data[1], exp_q.pop_front());
                exp_q.push_back(8'hA5);
                rd_en[1] = 1'b1;
                @(negedge clk);
                rd_en[1] = 1'b0;
            end
        join
        @(negedge clk);
        check("a5_no_ovr", 32'(ovr_n[1] - ovr0), 32'd1);
        check("a5_still_full", full[1], 1'b1);
        for (int i = 0; i < 16; i++) read_check(1, "drain");
        check("drain_empty", empty[1], 1'b1);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        check("b_no_fe", 32'(fe_n[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
